z80_bus_bridge: RTL and testbench
=================================

Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16: ack wait limit in CLK cycles, range 2..255.
REQ-002 Parameter IACK_VECTOR, default 8'hFF: byte returned on interrupt-acknowledge cycles.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 nRESET  input  1  asynchronous, active-low reset.
REQ-005 nMREQ, nIORQ, nRD, nWR, nM1, nRFSH  input  1 each  active-low Z80 bus controls from the core.
REQ-006 A  input  16  Z80 address bus.
REQ-007 WRITE_D  input  8  core write data.
REQ-008 READ_D  output  8  read data to the core.
REQ-009 nWAIT  output  1  active-low wait request to the core.
REQ-010 req  output  1  transaction request to the backing target.
REQ-011 req_we, req_io  output  1 each  write flag; I/O-space flag (0 = memory).
REQ-012 req_addr  output  16  transaction address.
REQ-013 req_wdata  output  8  transaction write data.
REQ-014 ack  input  1  target completion strobe, one cycle.
REQ-015 ack_rdata  input  8  read data, valid with ack.
REQ-016 err  output  1  one-cycle pulse on timeout or protocol error.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD.
REQ-018 Start condition: in IDLE, (!nMREQ or !nIORQ) and (!nRD or !nWR) and nRFSH high.
REQ-019 Refresh cycles (nMREQ and nRFSH low) SHALL NOT start a transaction.
REQ-020 Interrupt acknowledge (nM1 and nIORQ low): no transaction; READ_D SHALL equal IACK_VECTOR from the next edge; nWAIT stays high.
REQ-021 On start: latch A, WRITE_D, !nWR, !nIORQ into req_addr, req_wdata, req_we, req_io; go to REQ; req = 1 from the next cycle.
REQ-022 req_* outputs SHALL stay stable while req is high.
REQ-023 nWAIT SHALL be low combinationally in the start cycle, and low throughout REQ.
REQ-024 In REQ with ack high: req = 0; READ_D = ack_rdata if read, unchanged if write; go to HOLD; nWAIT high from the next cycle.
REQ-025 Minimum latency SHALL be: start detected at edge k, req high k..k+1, ack at edge k+1, nWAIT released after edge k+1.
REQ-026 Timeout counter SHALL clear on entering REQ and increment each REQ cycle.
REQ-027 Timeout: at count == TIMEOUT-1 without ack, drop req, set READ_D = 8'hFF, pulse err, go to HOLD.
REQ-028 Ack arriving in the same cycle as timeout SHALL win (normal completion, no err).
REQ-029 HOLD SHALL return to IDLE when nRD, nWR, nMREQ and nIORQ are all high.
REQ-030 If nRD and nWR both go high while in REQ, req SHALL be held until ack or timeout, then pulse err.
REQ-031 ack outside REQ SHALL be ignored.
REQ-032 Back-to-back bus cycles: a new start SHALL be accepted in the first IDLE cycle after HOLD.

Reset
REQ-033 nRESET low SHALL immediately force IDLE, req=0, req_we=0, req_io=0, req_addr=0, req_wdata=0, READ_D=8'hFF, nWAIT=1, err=0, counter=0.
REQ-034 Reset mid-REQ SHALL abandon the transaction with no err pulse.

Structure
REQ-035 State enum and default TIMEOUT/IACK_VECTOR constants SHALL live in shared package z80_bus_pkg.
REQ-036 Single module; no sub-module required.

Verification
REQ-037 Memory read A=16'h1234 with ack one cycle after req, ack_rdata=8'h5A -> req_io=0, READ_D=8'h5A, nWAIT low exactly 2 cycles.
REQ-038 I/O write A=16'h00FE, WRITE_D=8'hC3 with ack after 5 cycles -> req_io=1, req_we=1, req_wdata=8'hC3, nWAIT low 6 cycles.
REQ-039 Read with no ack, TIMEOUT=4 -> req drops after 4 REQ cycles, err pulses once, READ_D=8'hFF.
REQ-040 Refresh cycle (nMREQ low, nRFSH low) followed by M1 read -> no req for refresh; exactly one req for the M1 read.
REQ-041 nRESET asserted while in REQ -> req=0, nWAIT=1 asynchronously; a later ack causes no change.
REQ-042 Interrupt acknowledge with IACK_VECTOR=8'hE7 -> READ_D=8'hE7, req never asserted.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared state type and default constants for the Z80 bus bridge.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } bus_state_e;

    localparam int unsigned DEFAULT_TIMEOUT     = 16;
    localparam logic [7:0]  DEFAULT_IACK_VECTOR = 8'hFF;
    localparam logic [7:0]  TIMEOUT_RDATA       = 8'hFF;

endpackage

// File: rtl/z80_bus_bridge.sv
// Bridges Z80 memory/I-O bus cycles onto a simple req/ack target port,
// stretching the core with nWAIT until the target answers or times out.
module z80_bus_bridge
    import z80_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter logic [7:0]  IACK_VECTOR = DEFAULT_IACK_VECTOR
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nM1,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  WRITE_D,
    output logic [7:0]  READ_D,
    output logic        nWAIT,
    output logic        req,
    output logic        req_we,
    output logic        req_io,
    output logic [15:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        ack,
    input  logic [7:0]  ack_rdata,
    output logic        err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        io_q, io_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        orphan_q, orphan_d;
    logic        iack, start, core_idle, wait_n;

    assign iack      = !nM1 && !nIORQ;
    assign start     = (!nMREQ || !nIORQ) && (!nRD || !nWR) && nRFSH && !iack;
    assign core_idle = nRD && nWR && nMREQ && nIORQ;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        io_d     = io_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        orphan_d = orphan_q;
        err_d    = 1'b0;
        wait_n   = 1'b1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wait_n   = 1'b0;
                    state_d  = REQ;
                    req_d    = 1'b1;
                    we_d     = !nWR;
                    io_d     = !nIORQ;
                    addr_d   = A;
                    wdata_d  = WRITE_D;
                    cnt_d    = '0;
                    orphan_d = 1'b0;
                end else if (iack) begin
                    rdata_d = IACK_VECTOR;
                end
            end
            REQ: begin
                wait_n = 1'b0;
                cnt_d  = cnt_q + 8'd1;
                // Core walked away mid-transaction; finish with the target, then flag it.
                if (nRD && nWR) orphan_d = 1'b1;
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = HOLD;
                    if (!we_q) rdata_d = ack_rdata;
                    err_d   = orphan_q || (nRD && nWR);
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    rdata_d = TIMEOUT_RDATA;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (core_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            io_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= 8'hFF;
            err_q    <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            io_q     <= io_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            orphan_q <= orphan_d;
        end
    end

    // The start-cycle wait is combinational, so mask it while reset is held.
    assign nWAIT     = wait_n | !nRESET;
    assign req       = req_q;
    assign req_we    = we_q;
    assign req_io    = io_q;
    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign READ_D    = rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed self-checking bench: dut0 uses TIMEOUT=16/IACK=E7, dut1 uses TIMEOUT=4.
module tb_z80_bus_bridge;

    logic        CLK, nRESET;
    logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
    logic [15:0] A;
    logic [7:0]  WRITE_D;
    logic        ack;
    logic [7:0]  ack_rdata;

    logic [7:0]  read_d0, read_d1, wdata0, wdata1;
    logic        nwait0, nwait1, req0, req1, we0, we1, io0, io1, err0, err1;
    logic [15:0] addr0, addr1;

    z80_bus_bridge #(.TIMEOUT(16), .IACK_VECTOR(8'hE7)) dut0 (
        .CLK(CLK), .nRESET(nRESET), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nM1(nM1), .nRFSH(nRFSH), .A(A), .WRITE_D(WRITE_D), .READ_D(read_d0),
        .nWAIT(nwait0), .req(req0), .req_we(we0), .req_io(io0), .req_addr(addr0),
        .req_wdata(wdata0), .ack(ack), .ack_rdata(ack_rdata), .err(err0)
    );

    z80_bus_bridge #(.TIMEOUT(4)) dut1 (
        .CLK(CLK), .nRESET(nRESET), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
        .nM1(nM1), .nRFSH(nRFSH), .A(A), .WRITE_D(WRITE_D), .READ_D(read_d1),
        .nWAIT(nwait1), .req(req1), .req_we(we1), .req_io(io1), .req_addr(addr1),
        .req_wdata(wdata1), .ack(ack), .ack_rdata(ack_rdata), .err(err1)
    );

    logic        sel;
    logic        m_req, m_nwait, m_err, m_we, m_io;
    logic [7:0]  m_rdata, m_wdata;
    logic [15:0] m_addr;
    assign m_req   = sel ? req1   : req0;
    assign m_nwait = sel ? nwait1 : nwait0;
    assign m_err   = sel ? err1   : err0;
    assign m_we    = sel ? we1    : we0;
    assign m_io    = sel ? io1    : io0;
    assign m_rdata = sel ? read_d1 : read_d0;
    assign m_wdata = sel ? wdata1 : wdata0;
    assign m_addr  = sel ? addr1  : addr0;

    int errors = 0;
    int checks = 0;

    int          bc_waits, bc_reqs, bc_errs;
    logic [15:0] bc_addr;
    logic        bc_we, bc_io;
    logic [7:0]  bc_wd;
    bit          bc_stable;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic bus_idle();
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRESET = 1'b0;
        bus_idle();
        ack = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
    endtask

    // Runs one core bus cycle; ack is driven in REQ cycle ack_at (0 = never).
    task automatic bus_cycle(input bit io, input bit wr, input bit m1, input logic [15:0] addr,
                             input logic [7:0] wd, input int ack_at, input logic [7:0] rd);
        bit done = 0;
        bc_waits = 0; bc_reqs = 0; bc_errs = 0; bc_stable = 1;
        bc_addr = '0; bc_we = 0; bc_io = 0; bc_wd = '0;
        @(posedge CLK); #1;
        nMREQ = io; nIORQ = !io; nRD = wr; nWR = !wr; nM1 = !m1; A = addr; WRITE_D = wd;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin @(posedge CLK); #1; end
            ack = (ack_at > 0) && (c == ack_at);
            ack_rdata = rd;
            @(negedge CLK);
            if (!m_nwait) bc_waits++;
            if (m_req) begin
                if (bc_reqs == 0) begin
                    bc_addr = m_addr; bc_we = m_we; bc_io = m_io; bc_wd = m_wdata;
                end else if (m_addr !== bc_addr || m_we !== bc_we || m_io !== bc_io ||
                             m_wdata !== bc_wd) begin
                    bc_stable = 0;
                end
                bc_reqs++;
            end
            if (m_err) bc_errs++;
            if (c > 0 && m_nwait) done = 1;
        end
        @(posedge CLK); #1;
        ack = 1'b0;
        bus_idle();
        repeat (3) begin
            @(negedge CLK);
            if (m_err) bc_errs++;
            if (m_req) bc_reqs++;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        #12;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h want 0", m_req); end
        checks++; if (m_nwait !== 1'b1) begin errors++; $display("FAIL rst_nwait: got %0h want 1", m_nwait); end
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL rst_rdata: got %h want ff", m_rdata); end
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h want 0", m_err); end
        checks++; if (m_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", m_addr); end
        checks++; if ({m_we, m_io} !== 2'b00) begin
            errors++; $display("FAIL rst_we_io: got %b want 00", {m_we, m_io});
        end
        checks++; if (m_wdata !== 8'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", m_wdata); end
        @(negedge CLK);
        nRESET = 1'b1;
        // ack with no transaction outstanding must be ignored
        @(posedge CLK); #1; ack = 1'b1; ack_rdata = 8'h99;
        @(posedge CLK); #1; ack = 1'b0;
        @(negedge CLK);
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL stray_ack_rdata: got %h want ff", m_rdata); end
        checks++; if ({m_req, m_err} !== 2'b00) begin
            errors++; $display("FAIL stray_ack_req_err: got %b want 00", {m_req, m_err});
        end
    endtask

    task automatic test_mem_read();
        sel = 0;
        do_reset();
        bus_cycle(0, 0, 0, 16'h1234, 8'h00, 1, 8'h5A);
        checks++; if (bc_waits !== 2) begin errors++; $display("FAIL rd_waits: got %0d want 2", bc_waits); end
        checks++; if (bc_reqs !== 1) begin errors++; $display("FAIL rd_reqs: got %0d want 1", bc_reqs); end
        checks++; if (bc_addr !== 16'h1234) begin errors++; $display("FAIL rd_addr: got %h want 1234", bc_addr); end
        checks++; if ({bc_we, bc_io} !== 2'b00) begin
            errors++; $display("FAIL rd_we_io: got %b want 00", {bc_we, bc_io});
        end
        checks++; if (m_rdata !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h want 5a", m_rdata); end
        checks++; if (bc_errs !== 0) begin errors++; $display("FAIL rd_err: got %0d want 0", bc_errs); end
    endtask

    task automatic test_io_write();
        sel = 0;
        do_reset();
        bus_cycle(1, 1, 0, 16'h00FE, 8'hC3, 5, 8'h44);
        checks++; if (bc_waits !== 6) begin errors++; $display("FAIL wr_waits: got %0d want 6", bc_waits); end
        checks++; if (bc_reqs !== 5) begin errors++; $display("FAIL wr_reqs: got %0d want 5", bc_reqs); end
        checks++; if ({bc_we, bc_io} !== 2'b11) begin
            errors++; $display("FAIL wr_we_io: got %b want 11", {bc_we, bc_io});
        end
        checks++; if (bc_wd !== 8'hC3) begin errors++; $display("FAIL wr_wdata: got %h want c3", bc_wd); end
        checks++; if (bc_addr !== 16'h00FE) begin errors++; $display("FAIL wr_addr: got %h want 00fe", bc_addr); end
        checks++; if (bc_stable !== 1'b1) begin errors++; $display("FAIL wr_stable: got %0d want 1", bc_stable); end
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL wr_rdata_kept: got %h want ff", m_rdata); end
        checks++; if (bc_errs !== 0) begin errors++; $display("FAIL wr_err: got %0d want 0", bc_errs); end
    endtask

    task automatic test_timeout();
        sel = 1;
        do_reset();
        bus_cycle(0, 0, 0, 16'h8000, 8'h00, 1, 8'h3C);
        checks++; if (m_rdata !== 8'h3C) begin errors++; $display("FAIL to_pre_rdata: got %h want 3c", m_rdata); end
        bus_cycle(0, 0, 0, 16'h8001, 8'h00, 0, 8'h00);
        checks++; if (bc_reqs !== 4) begin errors++; $display("FAIL to_reqs: got %0d want 4", bc_reqs); end
        checks++; if (bc_waits !== 5) begin errors++; $display("FAIL to_waits: got %0d want 5", bc_waits); end
        checks++; if (bc_errs !== 1) begin errors++; $display("FAIL to_err: got %0d want 1", bc_errs); end
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL to_rdata: got %h want ff", m_rdata); end
        // ack on the last allowed cycle beats the timeout
        bus_cycle(0, 0, 0, 16'h8002, 8'h00, 4, 8'h77);
        checks++; if (bc_errs !== 0) begin errors++; $display("FAIL tie_err: got %0d want 0", bc_errs); end
        checks++; if (m_rdata !== 8'h77) begin errors++; $display("FAIL tie_rdata: got %h want 77", m_rdata); end
        checks++; if (bc_reqs !== 4) begin errors++; $display("FAIL tie_reqs: got %0d want 4", bc_reqs); end
        sel = 0;
    endtask

    task automatic test_refresh_m1();
        sel = 0;
        do_reset();
        @(posedge CLK); #1; nMREQ = 1'b0; nRFSH = 1'b0; A = 16'h007F;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++; if ({m_req, m_nwait} !== 2'b01) begin
                errors++; $display("FAIL rfsh_req_nwait[%0d]: got %b want 01", c, {m_req, m_nwait});
            end
        end
        @(posedge CLK); #1; bus_idle();
        bus_cycle(0, 0, 1, 16'h0100, 8'h00, 1, 8'h3E);
        checks++; if (bc_reqs !== 1) begin errors++; $display("FAIL m1_reqs: got %0d want 1", bc_reqs); end
        checks++; if (m_rdata !== 8'h3E) begin errors++; $display("FAIL m1_rdata: got %h want 3e", m_rdata); end
    endtask

    task automatic test_iack();
        int reqs_seen = 0;
        sel = 0;
        do_reset();
        @(posedge CLK); #1; nM1 = 1'b0; nIORQ = 1'b0;
        @(negedge CLK);
        checks++; if (m_nwait !== 1'b1) begin errors++; $display("FAIL iack_nwait: got %0h want 1", m_nwait); end
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL iack_early: got %h want ff", m_rdata); end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (m_req) reqs_seen++;
        end
        checks++; if (m_rdata !== 8'hE7) begin errors++; $display("FAIL iack_vec: got %h want e7", m_rdata); end
        @(posedge CLK); #1; bus_idle();
        @(negedge CLK);
        if (m_req) reqs_seen++;
        checks++; if (reqs_seen !== 0) begin errors++; $display("FAIL iack_req: got %0d want 0", reqs_seen); end
    endtask

    task automatic test_abandon();
        sel = 0;
        do_reset();
        @(posedge CLK); #1; nMREQ = 1'b0; nRD = 1'b0; A = 16'h4000;
        @(posedge CLK); #1; nMREQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL ab_req_held: got %0h want 1", m_req); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if ({m_req, m_err} !== 2'b10) begin
            errors++; $display("FAIL ab_wait: got %b want 10", {m_req, m_err});
        end
        @(posedge CLK); #1; ack = 1'b1; ack_rdata = 8'hAA;
        @(posedge CLK); #1; ack = 1'b0;
        @(negedge CLK);
        checks++; if ({m_req, m_err} !== 2'b01) begin
            errors++; $display("FAIL ab_err_pulse: got %b want 01", {m_req, m_err});
        end
        @(negedge CLK);
        checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL ab_err_once: got %0h want 0", m_err); end
    endtask

    task automatic test_reset_mid_req();
        sel = 0;
        do_reset();
        @(posedge CLK); #1; nMREQ = 1'b0; nRD = 1'b0; A = 16'h5555;
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL mr_pre_req: got %0h want 1", m_req); end
        #2; nRESET = 1'b0; #1;
        checks++; if ({m_req, m_nwait, m_err} !== 3'b010) begin
            errors++; $display("FAIL mr_async: got %b want 010", {m_req, m_nwait, m_err});
        end
        @(posedge CLK); #1; bus_idle(); nRESET = 1'b1; ack = 1'b1; ack_rdata = 8'h12;
        @(posedge CLK); #1; ack = 1'b0;
        @(negedge CLK);
        checks++; if (m_rdata !== 8'hFF) begin errors++; $display("FAIL mr_late_ack: got %h want ff", m_rdata); end
        checks++; if ({m_req, m_nwait, m_err} !== 3'b010) begin
            errors++; $display("FAIL mr_after: got %b want 010", {m_req, m_nwait, m_err});
        end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        do_reset();
        @(posedge CLK); #1; nMREQ = 1'b0; nRD = 1'b0; A = 16'h2000;
        @(posedge CLK); #1; ack = 1'b1; ack_rdata = 8'h11;
        @(posedge CLK); #1; ack = 1'b0;
        @(negedge CLK);
        checks++; if ({m_nwait, m_rdata} !== 9'h111) begin
            errors++; $display("FAIL b2b_first: got %h want 111", {m_nwait, m_rdata});
        end
        @(posedge CLK); #1; bus_idle();
        @(posedge CLK); #1; nMREQ = 1'b0; nWR = 1'b0; A = 16'h2001; WRITE_D = 8'h22;
        @(negedge CLK);
        checks++; if (m_nwait !== 1'b0) begin errors++; $display("FAIL b2b_start: got %0h want 0", m_nwait); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if ({m_req, m_we, m_addr, m_wdata} !== {2'b11, 16'h2001, 8'h22}) begin
            errors++; $display("FAIL b2b_req: got %h want 3200122", {m_req, m_we, m_addr, m_wdata});
        end
        @(posedge CLK); #1; ack = 1'b1;
        @(posedge CLK); #1; ack = 1'b0;
        @(negedge CLK);
        checks++; if ({m_rdata, m_err} !== 9'h022) begin
            errors++; $display("FAIL b2b_done: got %h want 022", {m_rdata, m_err});
        end
        @(posedge CLK); #1; bus_idle();
    endtask

    initial begin
        nRESET = 1'b0;
        bus_idle();
        A = '0; WRITE_D = '0; ack = 1'b0; ack_rdata = '0; sel = 0;
        test_reset();
        test_mem_read();
        test_io_write();
        test_timeout();
        test_refresh_m1();
        test_iack();
        test_abandon();
        test_reset_mid_req();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
